ysyx_23060111_dmem_resp: RTL and testbench



---
 rtl/ysyx_23060111_dmem_resp.sv | 218 +++++++++++++++++++++
 tb/tb_ysyx_23060111_dmem_resp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060111_dmem_resp.sv
// Data-memory responder: one request at a time, LAT wait cycles, byte-lane SRAM.
// Define DMEM_UNALIGNED_EN to allow misaligned and word-split accesses.
module ysyx_23060111_dmem_resp #(
   parameter logic [31:0] BASE  = 32'h8000_0000,
   parameter int          DEPTH = 4096,
   parameter int          LAT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_mask,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACC,
      S_ACC2,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wen_q, wen_d;
   logic [1:0]    off_q, off_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [2:0]    size_q, size_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic [31:0]   buf_q, buf_d;
   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [31:0]   mem [DEPTH];

   logic          mask_ok;
   logic [2:0]    req_size;
   logic [32:0]   a33, lo33, last33, hi33;
   logic          range_bad, align_bad, req_err;
   logic [AW-1:0] req_idx;

   logic          split;
   logic [AW-1:0] rd_idx;
   logic [31:0]   rd_word;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wd;
   logic [31:0]   ld_bytes;
   logic [2:0]    pos;
   logic          mem_we;

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // 33-bit bounds so a request wrapping past 0xFFFFFFFF is rejected
   always_comb begin
      mask_ok   = (req_mask == 32'd1) || (req_mask == 32'd2) ||
                  (req_mask == 32'd4);
      req_size  = mask_ok ? req_mask[2:0] : 3'd1;
      a33       = {1'b0, req_addr};
      lo33      = {1'b0, BASE};
      last33    = a33 + {30'b0, req_size} - 33'd1;
      hi33      = lo33 + (33'(DEPTH) << 2) - 33'd1;
      range_bad = (a33 < lo33) || (last33 > hi33);
`ifdef DMEM_UNALIGNED_EN
      align_bad = 1'b0;
`else
      align_bad = ((req_size == 3'd2) && req_addr[0]) ||
                  ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
`endif
      req_err   = !mask_ok || range_bad || align_bad;
      req_idx   = AW'((req_addr - BASE) >> 2);
   end

`ifdef DMEM_UNALIGNED_EN
   assign split = ({1'b0, off_q} + size_q) > 3'd4;
`else
   assign split = 1'b0;
`endif

   assign rd_idx  = (state_q == S_ACC2) ? idx_q + AW'(1) : idx_q;
   assign rd_word = mem[rd_idx];
   assign mem_we  = wen_q && !err_q &&
                    ((state_q == S_ACC) || (state_q == S_ACC2));

   // byte k of the request lives at lane off+k; lanes >= 4 spill to next word
   always_comb begin
      lane_be  = '0;
      lane_wd  = '0;
      ld_bytes = '0;
      pos      = '0;
      for (int k = 0; k < 4; k++) begin
         pos = {1'b0, off_q} + 3'(k);
         if ((3'(k) < size_q) && (pos[2] == (state_q == S_ACC2))) begin
            lane_be[pos[1:0]]           = 1'b1;
            lane_wd[8*pos[1:0] +: 8]    = wdata_q[8*k +: 8];
            ld_bytes[8*k +: 8]          = rd_word[8*pos[1:0] +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (mem_we && lane_be[l]) begin
            mem[rd_idx][8*l +: 8] <= lane_wd[8*l +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wen_d       = wen_q;
      off_d       = off_q;
      idx_d       = idx_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      buf_d       = buf_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               wen_d   = req_wen;
               off_d   = req_addr[1:0];
               idx_d   = req_idx;
               size_d  = req_size;
               wdata_d = req_wdata;
               err_d   = req_err;
               if (LAT == 0) begin
                  state_d = S_ACC;
               end else begin
                  cnt_d   = 4'(LAT);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            buf_d = ld_bytes;
            if (split && !err_q) begin
               state_d = S_ACC2;
            end else begin
               state_d     = S_RESP;
               rsp_rdata_d = (wen_q || err_q) ? 32'd0 : ld_bytes;
               rsp_err_d   = err_q;
            end
         end
         S_ACC2: begin
            state_d     = S_RESP;
            rsp_rdata_d = wen_q ? 32'd0 : (buf_q | ld_bytes);
            rsp_err_d   = err_q;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wen_q       <= 1'b0;
         off_q       <= '0;
         idx_q       <= '0;
         size_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         buf_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         off_q       <= off_d;
         idx_q       <= idx_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         buf_q       <= buf_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_23060111_dmem_resp.sv
// Directed bench for ysyx_23060111_dmem_resp (LAT=1, DEPTH=4096).
// Honours DMEM_UNALIGNED_EN for the misaligned-store expectations.
module tb_ysyx_23060111_dmem_resp;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_mask = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_23060111_dmem_resp #(
      .BASE (32'h8000_0000),
      .DEPTH(4096),
      .LAT  (LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wen  (req_wen),
      .req_addr (req_addr),
      .req_mask (req_mask),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic w,
                       input logic [31:0] a, input logic [31:0] m,
                       input logic [31:0] d, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat);
      int lat;
      logic [31:0] rd;
      @(negedge clk);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_wen   = w;
      req_addr  = a;
      req_mask  = m;
      req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!rsp_valid && lat < 20);
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
      rd = exp_rd;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, ".hold_rdata"}, rsp_rdata, rd);
         chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".done_ready"}, 32'(req_ready), 32'd1);
      chk({tag, ".done_rdata"}, rsp_rdata, 32'd0);
   endtask

   initial begin
      #12;
      chk("rst.req_ready", 32'(req_ready), 32'd1);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.rsp_rdata", rsp_rdata, 32'd0);
      chk("rst.rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      xfer("st_word", 1, 32'h8000_0010, 4, 32'hDEAD_BEEF, 0, 0, 0, 2);
      xfer("ld_word", 0, 32'h8000_0010, 4, 0, 0, 32'hDEAD_BEEF, 0, 2);
      xfer("st_byte", 1, 32'h8000_0013, 1, 32'h0000_00AA, 0, 0, 0, 2);
      xfer("ld_merge", 0, 32'h8000_0010, 4, 0, 0, 32'hAAAD_BEEF, 0, 2);
      xfer("ld_half", 0, 32'h8000_0012, 2, 0, 0, 32'h0000_AAAD, 0, 2);
      xfer("ld_byte", 0, 32'h8000_0011, 1, 0, 0, 32'h0000_00BE, 0, 2);
      xfer("backpr", 0, 32'h8000_0010, 4, 0, 5, 32'hAAAD_BEEF, 0, 2);

      // idle rsp_ready must not create a response
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("idle_rdy.valid", 32'(rsp_valid), 32'd0);
         chk("idle_rdy.ready", 32'(req_ready), 32'd1);
      end
      rsp_ready = 1'b0;

      xfer("st_base", 1, 32'h8000_0000, 4, 32'h1234_5678, 0, 0, 0, 2);
      xfer("st_last", 1, 32'h8000_3FFC, 4, 32'h0BAD_F00D, 0, 0, 0, 2);
      xfer("ld_last", 0, 32'h8000_3FFC, 4, 0, 0, 32'h0BAD_F00D, 0, 2);
      xfer("err_low", 0, 32'h7FFF_FFFC, 4, 0, 0, 0, 1, 2);
      xfer("err_high", 0, 32'h8000_3FFE, 4, 0, 0, 0, 1, 2);
      xfer("err_mask", 0, 32'h8000_0000, 3, 0, 0, 0, 1, 2);
      xfer("err_wrap", 0, 32'hFFFF_FFFE, 4, 0, 0, 0, 1, 2);
      xfer("err_stlo", 1, 32'h7FFF_FFFC, 4, 32'hFFFF_FFFF, 0, 0, 1, 2);
      xfer("err_stmk", 1, 32'h8000_0000, 3, 32'hFFFF_FFFF, 0, 0, 1, 2);
      xfer("ld_base", 0, 32'h8000_0000, 4, 0, 0, 32'h1234_5678, 0, 2);

      xfer("pre_w20", 1, 32'h8000_0020, 4, 32'hAAAA_AAAA, 0, 0, 0, 2);
      xfer("pre_w24", 1, 32'h8000_0024, 4, 32'hBBBB_BBBB, 0, 0, 0, 2);
`ifdef DMEM_UNALIGNED_EN
      xfer("st_split", 1, 32'h8000_0022, 4, 32'h1122_3344, 0, 0, 0, 3);
      xfer("ld_w20", 0, 32'h8000_0020, 4, 0, 0, 32'h3344_AAAA, 0, 2);
      xfer("ld_w24", 0, 32'h8000_0024, 4, 0, 0, 32'hBBBB_1122, 0, 2);
      xfer("ld_split", 0, 32'h8000_0022, 4, 0, 0, 32'h1122_3344, 0, 3);
      xfer("ld_hsplit", 0, 32'h8000_0023, 2, 0, 0, 32'h0000_2233, 0, 3);
      xfer("ld_mis", 0, 32'h8000_0021, 2, 0, 0, 32'h0000_44AA, 0, 2);
`else
      xfer("st_split", 1, 32'h8000_0022, 4, 32'h1122_3344, 0, 0, 1, 2);
      xfer("ld_w20", 0, 32'h8000_0020, 4, 0, 0, 32'hAAAA_AAAA, 0, 2);
      xfer("ld_w24", 0, 32'h8000_0024, 4, 0, 0, 32'hBBBB_BBBB, 0, 2);
      xfer("ld_mis", 0, 32'h8000_0021, 2, 0, 0, 0, 1, 2);
`endif

      // reset while the store sits in WAIT
      xfer("pre_w30", 1, 32'h8000_0030, 4, 32'h5555_5555, 0, 0, 0, 2);
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 32'h8000_0030;
      req_mask  = 4;
      req_wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst.req_ready", 32'(req_ready), 32'd1);
      chk("mid_rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst.rsp_rdata", rsp_rdata, 32'd0);
      chk("mid_rst.rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("post_rst.valid", 32'(rsp_valid), 32'd0);
      xfer("ld_w30", 0, 32'h8000_0030, 4, 0, 0, 32'h5555_5555, 0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
